// File: rtl/ws281x_pkg.sv
// Shared types and default timing for the WS281x receiver and driver.
// Timing constants are in clock cycles at the default 25 MHz clock.
package ws281x_pkg;

   localparam int WordWidth = 24;

   localparam int DefClkFreq         = 25_000_000;
   localparam int DefMinHighCycles   = 3;
   localparam int DefBitThreshCycles = 15;
   localparam int DefMaxHighCycles   = 30;
   localparam int DefResetCycles     = 1250;

   // Nominal transmit timing used by the driver side.
   localparam int T0HCycles = 10;
   localparam int T1HCycles = 20;
   localparam int BitCycles = 31;

   typedef enum logic [1:0] {
      WAIT_GAP = 2'd0,
      IDLE     = 2'd1,
      HIGH     = 2'd2,
      LOW      = 2'd3
   } rx_state_e;

endpackage

// File: rtl/ws281x_rx_if.sv
// Decoded-word stream from the WS281x receiver to its consumer.
interface ws281x_rx_if;
   import ws281x_pkg::*;

   // valid/ready: a word transfers on a rising clk edge where data_valid_o and
   // data_ready_i are both high; data_o is stable while valid waits for ready.
   logic [WordWidth-1:0] data_o;
   logic                 data_valid_o;
   logic                 data_ready_i;

   modport master (output data_o, output data_valid_o, input data_ready_i);
   modport slave  (input data_o, input data_valid_o, output data_ready_i);
endinterface

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for bringing an asynchronous level into the clk domain.
module prim_flop_2sync #(
   parameter int          Width      = 1,
   parameter logic [Width-1:0] ResetValue = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] meta;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta <= ResetValue;
         q_o  <= ResetValue;
      end else begin
         meta <= d_i;
         q_o  <= meta;
      end
   end

endmodule

// File: rtl/ws281x_rx.sv
// WS281x single-wire receiver: measures high-pulse widths to decode bits,
// assembles 24-bit words and detects the low reset gap that ends a frame.
module ws281x_rx
   import ws281x_pkg::*;
#(
   parameter int ClkFreq         = DefClkFreq,
   parameter int MinHighCycles   = DefMinHighCycles,
   parameter int BitThreshCycles = DefBitThreshCycles,
   parameter int MaxHighCycles   = DefMaxHighCycles,
   parameter int ResetCycles     = DefResetCycles
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       din_i,
   ws281x_rx_if.master rx,
   output logic       frame_end_o,
   output logic       err_o,
   output logic       overflow_o,
   output logic       idle_o,
   output rx_state_e  state_o
);

   localparam int CntW = $clog2(ResetCycles + 1);
   localparam logic [CntW-1:0] CntOne     = CntW'(1);
   localparam logic [CntW-1:0] CntMax     = '1;
   localparam logic [CntW-1:0] MinHighC   = CntW'(MinHighCycles);
   localparam logic [CntW-1:0] BitThreshC = CntW'(BitThreshCycles);
   localparam logic [CntW-1:0] MaxHighP1C = CntW'(MaxHighCycles + 1);
   localparam logic [CntW-1:0] ResetC     = CntW'(ResetCycles);
   localparam logic [4:0]      LastBit    = 5'(WordWidth - 1);

   if (ClkFreq <= 0 || MinHighCycles > BitThreshCycles ||
       BitThreshCycles > MaxHighCycles || MaxHighCycles + 1 >= ResetCycles) begin : g_param_check
      $error("ws281x_rx: inconsistent timing parameters");
   end

   logic din_s, din_q, rise, fall;
   rx_state_e state, state_next;
   logic [CntW-1:0] cnt, cnt_next, cnt_inc;
   logic [4:0] bit_cnt, bit_cnt_next;
   logic [WordWidth-1:0] shreg, shreg_next;
   logic word_done, word_done_next;
   logic err_set, frame_set;

   prim_flop_2sync #(.Width(1), .ResetValue(1'b0)) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (din_i),
      .q_o   (din_s)
   );

   assign rise    = din_s & ~din_q;
   assign fall    = ~din_s & din_q;
   assign cnt_inc = (cnt == CntMax) ? cnt : cnt + CntOne;
   assign state_o = state;

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= WAIT_GAP;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         WAIT_GAP: if (!din_s && cnt_inc == ResetC) state_next = IDLE;
         IDLE:     if (rise) state_next = HIGH;
         HIGH: begin
            if (fall) state_next = (cnt < MinHighC) ? WAIT_GAP : LOW;
            else if (cnt_inc == MaxHighP1C) state_next = WAIT_GAP;
         end
         LOW: begin
            if (rise) state_next = HIGH;
            else if (cnt_inc == ResetC) state_next = IDLE;
         end
         default: state_next = WAIT_GAP;
      endcase
   end

   always_comb begin
      cnt_next       = cnt;
      bit_cnt_next   = bit_cnt;
      shreg_next     = shreg;
      word_done_next = 1'b0;
      err_set        = 1'b0;
      frame_set      = 1'b0;
      unique case (state)
         WAIT_GAP: cnt_next = din_s ? '0 : cnt_inc;
         IDLE:     if (rise) cnt_next = CntOne;
         HIGH: begin
            if (fall) begin
               if (cnt < MinHighC) begin
                  err_set      = 1'b1;
                  bit_cnt_next = '0;
                  cnt_next     = '0;
               end else begin
                  shreg_next = {shreg[WordWidth-2:0], (cnt >= BitThreshC)};
                  cnt_next   = CntOne;
                  if (bit_cnt == LastBit) begin
                     bit_cnt_next   = '0;
                     word_done_next = 1'b1;
                  end else begin
                     bit_cnt_next = bit_cnt + 5'd1;
                  end
               end
            end else if (cnt_inc == MaxHighP1C) begin
               err_set      = 1'b1;
               bit_cnt_next = '0;
               cnt_next     = '0;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         LOW: begin
            if (rise) begin
               cnt_next = CntOne;
            end else begin
               cnt_next = cnt_inc;
               // A reset gap with bits pending means the word was truncated.
               if (cnt_inc == ResetC) begin
                  frame_set    = 1'b1;
                  err_set      = (bit_cnt != '0);
                  bit_cnt_next = '0;
               end
            end
         end
         default: cnt_next = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         din_q       <= 1'b0;
         cnt         <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         word_done   <= 1'b0;
         err_o       <= 1'b0;
         frame_end_o <= 1'b0;
         idle_o      <= 1'b0;
      end else begin
         din_q       <= din_s;
         cnt         <= cnt_next;
         bit_cnt     <= bit_cnt_next;
         shreg       <= shreg_next;
         word_done   <= word_done_next;
         err_o       <= err_set;
         frame_end_o <= frame_set;
         idle_o      <= (state_next == WAIT_GAP) || (state_next == IDLE);
      end
   end

   // A completed word is dropped only if the held word is not leaving this cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx.data_o       <= '0;
         rx.data_valid_o <= 1'b0;
         overflow_o      <= 1'b0;
      end else begin
         overflow_o <= 1'b0;
         if (word_done) begin
            if (rx.data_valid_o && !rx.data_ready_i) begin
               overflow_o <= 1'b1;
            end else begin
               rx.data_o       <= shreg;
               rx.data_valid_o <= 1'b1;
            end
         end else if (rx.data_valid_o && rx.data_ready_i) begin
            rx.data_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ws281x_rx.sv
// Bench for ws281x_rx: drives timed WS281x waveforms and scoreboards decoded words.
module tb_ws281x_rx;
   import ws281x_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic din = 1'b0;
   logic frame_end, err, overflow, idle;
   rx_state_e state;

   ws281x_rx_if rx_if ();

   ws281x_rx dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .din_i       (din),
      .rx          (rx_if.master),
      .frame_end_o (frame_end),
      .err_o       (err),
      .overflow_o  (overflow),
      .idle_o      (idle),
      .state_o     (state)
   );

   always #20 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [WordWidth-1:0] exp_q[$];
   int n_cmp = 0;
   int n_mis = 0;
   int n_frame = 0, n_err = 0, n_both = 0, n_ovf = 0, n_vrise = 0;
   int last_vrise_cyc = 0, last_err_cyc = 0, last_fall_cyc = 0, rise_cyc = 0;
   logic valid_prev = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Sampled mid-cycle: a handshake seen here transfers on the next rising edge.
   initial begin
      logic [WordWidth-1:0] exp_w;
      forever begin
         @(negedge clk);
         #5;
         if (!rst) begin
            if (frame_end) n_frame++;
            if (err) begin
               n_err++;
               last_err_cyc = cyc;
            end
            if (err && frame_end) n_both++;
            if (overflow) n_ovf++;
            if (rx_if.data_valid_o && !valid_prev) begin
               n_vrise++;
               last_vrise_cyc = cyc;
            end
            if (rx_if.data_valid_o && rx_if.data_ready_i) begin
               exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
               check_eq("word", 32'(rx_if.data_o), 32'(exp_w));
            end
         end
         valid_prev = rx_if.data_valid_o;
      end
   end

   task automatic low(input int n);
      din = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input bit ready_at_done);
      int hi;
      hi = b ? T1HCycles : T0HCycles;
      din = 1'b1;
      repeat (hi) @(negedge clk);
      din = 1'b0;
      last_fall_cyc = cyc;
      for (int k = 1; k <= BitCycles - hi; k++) begin
         @(negedge clk);
         if (ready_at_done && k == 3) rx_if.data_ready_i = 1'b1;
      end
   endtask

   task automatic send_bits(input logic [WordWidth-1:0] w, input int count, input bit ready_at_done);
      for (int i = WordWidth - 1; i >= WordWidth - count; i--)
         send_bit(w[i], ready_at_done && (i == 0));
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int f0, e0, b0, o0, v0;
      rx_if.data_ready_i = 1'b0;
      repeat (5) @(negedge clk);
      settle();
      check_eq("rst_data", 32'(rx_if.data_o), 32'h0);
      check_eq("rst_valid", 32'(rx_if.data_valid_o), 32'h0);
      check_eq("rst_pulses", {29'h0, frame_end, err, overflow}, 32'h0);
      check_eq("rst_idle", 32'(idle), 32'h0);
      check_eq("rst_state", 32'(state), 32'(WAIT_GAP));
      @(negedge clk);
      rst = 1'b0;

      // Basic word, latency and frame end.
      rx_if.data_ready_i = 1'b1;
      f0 = n_frame; e0 = n_err; v0 = n_vrise;
      low(1300);
      exp_q.push_back(24'hA50F3C);
      send_bits(24'hA50F3C, 24, 1'b0);
      low(1300);
      settle();
      check_eq("basic_vrise", 32'(n_vrise - v0), 32'd1);
      check_eq("basic_latency", 32'(last_vrise_cyc - last_fall_cyc), 32'd4);
      check_eq("basic_frame", 32'(n_frame - f0), 32'd1);
      check_eq("basic_err", 32'(n_err - e0), 32'd0);
      check_eq("basic_valid_cleared", 32'(rx_if.data_valid_o), 32'd0);
      check_eq("basic_idle", 32'(idle), 32'd1);

      // Overflow with ready held low.
      rx_if.data_ready_i = 1'b0;
      o0 = n_ovf;
      exp_q.push_back(24'h123456);
      send_bits(24'h123456, 24, 1'b0);
      send_bits(24'hABCDEF, 24, 1'b0);
      low(100);
      settle();
      check_eq("ovf_data_held", 32'(rx_if.data_o), 32'h123456);
      check_eq("ovf_valid", 32'(rx_if.data_valid_o), 32'd1);
      check_eq("ovf_count", 32'(n_ovf - o0), 32'd1);
      rx_if.data_ready_i = 1'b1;
      low(1300);

      // Handshake coinciding with the second completion.
      rx_if.data_ready_i = 1'b0;
      o0 = n_ovf;
      exp_q.push_back(24'h123456);
      send_bits(24'h123456, 24, 1'b0);
      exp_q.push_back(24'hABCDEF);
      send_bits(24'hABCDEF, 24, 1'b1);
      low(1300);
      settle();
      check_eq("coincide_ovf", 32'(n_ovf - o0), 32'd0);
      check_eq("coincide_data", 32'(rx_if.data_o), 32'hABCDEF);
      check_eq("coincide_drained", 32'(exp_q.size()), 32'd0);

      // Glitch mid-word.
      e0 = n_err; v0 = n_vrise;
      send_bits(24'hFF00FF, 8, 1'b0);
      din = 1'b1;
      repeat (2) @(negedge clk);
      low(29);
      send_bits(24'h00FFFF, 16, 1'b0);
      settle();
      check_eq("glitch_err", 32'(n_err - e0), 32'd1);
      check_eq("glitch_no_word", 32'(n_vrise - v0), 32'd0);
      @(negedge clk);
      low(1300);
      exp_q.push_back(24'h5A5A5A);
      send_bits(24'h5A5A5A, 24, 1'b0);
      low(1300);
      settle();
      check_eq("glitch_recover", 32'(n_vrise - v0), 32'd1);

      // Partial word followed by a reset gap.
      b0 = n_both; v0 = n_vrise; f0 = n_frame;
      @(negedge clk);
      send_bits(24'hC3C3C3, 12, 1'b0);
      low(1300);
      settle();
      check_eq("partial_err_frame", 32'(n_both - b0), 32'd1);
      check_eq("partial_frame", 32'(n_frame - f0), 32'd1);
      check_eq("partial_no_word", 32'(n_vrise - v0), 32'd0);

      // Over-long high pulse.
      e0 = n_err;
      @(negedge clk);
      din = 1'b1;
      rise_cyc = cyc;
      repeat (40) @(negedge clk);
      low(4);
      settle();
      check_eq("long_err", 32'(n_err - e0), 32'd1);
      check_eq("long_err_time", 32'(last_err_cyc - rise_cyc), 32'd33);
      check_eq("long_state", 32'(state), 32'(WAIT_GAP));
      check_eq("long_idle", 32'(idle), 32'd1);

      // Reset mid-word.
      @(negedge clk);
      low(1300);
      send_bits(24'h3C3C3C, 10, 1'b0);
      rst = 1'b1;
      settle();
      check_eq("midrst_data", 32'(rx_if.data_o), 32'h0);
      check_eq("midrst_outs", {27'h0, rx_if.data_valid_o, frame_end, err, overflow, idle}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      v0 = n_vrise;
      send_bits(24'h3C3C3C, 14, 1'b0);
      send_bits(24'h777777, 24, 1'b0);
      settle();
      check_eq("midrst_no_word", 32'(n_vrise - v0), 32'd0);
      @(negedge clk);
      low(1300);
      exp_q.push_back(24'h00FF00);
      send_bits(24'h00FF00, 24, 1'b0);
      low(1300);
      settle();
      check_eq("midrst_recover", 32'(n_vrise - v0), 32'd1);
      check_eq("final_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/ws281x_rx.md
WS281X_RX -- requirements
Module: ws281x_rx

Interface
REQ-001 Parameter ClkFreq, default 25_000_000, clk_i frequency in Hz.
REQ-002 Parameter MinHighCycles, default 3 (0.12 us): shorter high pulses are glitch errors.
REQ-003 Parameter BitThreshCycles, default 15 (0.6 us): a high pulse of at least this many cycles decodes as 1, otherwise as 0.
REQ-004 Parameter MaxHighCycles, default 30 (1.2 us): a longer high pulse is an error.
REQ-005 Parameter ResetCycles, default 1250 (50 us): a low time of this many cycles ends a frame.
REQ-006 clk_i  in  1  sole clock; one clock, all logic on the rising edge.
REQ-007 rst_i  in  1  reset, synchronous, active-high.
REQ-008 din_i  in  1  asynchronous WS281x serial line.
REQ-009 data_o  out  24  decoded word, first-received bit in bit 23 (G7..R0..B0 wire order).
REQ-010 data_valid_o  out  1  data_o holds an unconsumed word.
REQ-011 data_ready_i  in  1  consumer accepts; transfer occurs when valid and ready are both high.
REQ-012 frame_end_o  out  1  one-cycle pulse when a reset gap ends a frame.
REQ-013 err_o  out  1  one-cycle pulse on glitch, over-long high, or partial word.
REQ-014 overflow_o  out  1  one-cycle pulse when a completed word is dropped.
REQ-015 idle_o  out  1  high in states WAIT_GAP and IDLE.

Function
REQ-016 din_i passes through a 2-flop synchroniser; all decoding uses the synchronised value and its registered copy for edge detection.
REQ-017 The FSM has states WAIT_GAP, IDLE, HIGH and LOW, with one saturating counter of width $clog2(ResetCycles+1).
REQ-018 In WAIT_GAP, the counter increments while the line is low and clears on high; on reaching ResetCycles it moves to IDLE without pulsing frame_end_o.
REQ-019 In IDLE, a rising edge moves to HIGH with counter=1.
REQ-020 In HIGH, the counter increments each cycle; reaching MaxHighCycles+1 pulses err_o, clears bit_cnt and moves to WAIT_GAP.
REQ-021 In HIGH, on a falling edge: if counter<MinHighCycles, pulse err_o, clear bit_cnt, go to WAIT_GAP; otherwise shift bit (counter>=BitThreshCycles) into the LSB of the shift register, increment bit_cnt, go to LOW with counter=1.
REQ-022 When bit_cnt reaches 24, the word is complete: bit_cnt wraps to 0 and the word loads into data_o on the next cycle, with data_valid_o set.
REQ-023 If a word completes while data_valid_o=1 and data_ready_i=0, the new word is discarded, data_o is unchanged, and overflow_o pulses.
REQ-024 If a handshake and a word completion occur in the same cycle, the new word loads, data_valid_o stays 1, and there is no overflow.
REQ-025 In LOW, a rising edge goes to HIGH with counter=1; the counter reaching ResetCycles pulses frame_end_o, goes to IDLE, and also pulses err_o if bit_cnt!=0, then clears bit_cnt.
REQ-026 data_valid_o clears the cycle after a handshake unless a new word loads in that cycle.
REQ-027 Latency: data_valid_o rises 4 clk_i cycles after the final din_i falling edge, i.e. 2 synchroniser cycles, 1 edge-detect cycle and 1 load cycle.

Reset
REQ-028 While rst_i=1, all outputs are 0, the synchroniser flops are 0, counter=0, bit_cnt=0, and the state is WAIT_GAP.
REQ-029 Reset asserted mid-word discards the partial word, and after release a full ResetCycles low gap is required before decoding.

Structure
REQ-030 Package ws281x_pkg holds the rx_state_e enum, WordWidth=24, and default timing constants shared with ws281x_drv.
REQ-031 The only sub-module is prim_flop_2sync (Width=1, ResetValue=0) for din_i.

Verification (25 MHz; T0H=10, T1H=20 high cycles, bit period 31 cycles)
REQ-032 Low for 1300 cycles, then 24 bits of 0xA50F3C, then low for 1300 cycles -> data_o=0xA50F3C with data_valid_o 4 cycles after the last fall, then a single frame_end_o pulse and no err_o.
REQ-033 Two words 0x123456 and 0xABCDEF with data_ready_i=0 -> data_o stays 0x123456 and overflow_o pulses once; setting ready high in the same cycle as the second completion instead yields 0xABCDEF with no overflow.
REQ-034 A 2-cycle high pulse mid-word -> err_o pulse, no data_valid_o until a 1250-cycle gap and a new word.
REQ-035 12 valid bits then a 1300-cycle low -> err_o and frame_end_o in the same cycle, data_valid_o stays 0.
REQ-036 A 40-cycle high pulse -> err_o at cycle 31 of the high, then WAIT_GAP with idle_o=1.
REQ-037 rst_i for 1 cycle after bit 10 -> all outputs 0, and the next word decodes only after a 1250-cycle gap.
